// File: rtl/pwl_curve_lut.sv
// Piecewise-linear curve lookup: a table of NODES node values defines
// 2^SEG_W linear segments over the input range; each accepted sample x is
// mapped to y by interpolating between the two nodes that bound its segment.
//
// Build option: define PWL_DOUBLE_BUFFER_EN to add a shadow node table that
// software fills with cfg_we and publishes atomically with cfg_commit. When
// it is not defined, cfg_we writes the active table directly and cfg_commit
// has no effect.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   sample handshake (in_ready is combinational)
//   in_data [DW_X]      sample x
//   out_valid/out_ready result handshake
//   out_data [DW_Y]     interpolated y (registered)
//   cfg_we              node write strobe
//   cfg_addr [SEG_W+1]  node index; indices >= NODES are ignored
//   cfg_wdata [DW_Y]    node value
//   cfg_commit          shadow-to-active copy pulse
module pwl_curve_lut #(
    parameter int unsigned DW_X  = 10,
    parameter int unsigned DW_Y  = 9,
    parameter int unsigned SEG_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW_X-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW_Y-1:0]   out_data,
    input  logic              cfg_we,
    input  logic [SEG_W:0]    cfg_addr,
    input  logic [DW_Y-1:0]   cfg_wdata,
    input  logic              cfg_commit
);

    localparam int unsigned NODES = (1 << SEG_W) + 1;
    localparam int unsigned OFF_W = DW_X - SEG_W;
    localparam int unsigned IDX_W = SEG_W + 1;
    localparam int unsigned PW    = DW_Y + OFF_W + 2;

    // Node tables
    logic [DW_Y-1:0] active_tbl [NODES];
    logic            addr_ok;

    assign addr_ok = (cfg_addr < IDX_W'(NODES));

`ifdef PWL_DOUBLE_BUFFER_EN
    logic [DW_Y-1:0] shadow_tbl [NODES];

    // Shadow table: software-visible staging copy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_tbl <= '{default: '0};
        end else if (cfg_we && addr_ok) begin
            shadow_tbl[cfg_addr] <= cfg_wdata;
        end
    end

    // Active table: whole-table copy on commit; a same-edge shadow write
    // is not seen here because the copy samples the pre-edge shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_tbl <= '{default: '0};
        end else if (cfg_commit) begin
            active_tbl <= shadow_tbl;
        end
    end
`else
    logic unused_commit;
    assign unused_commit = cfg_commit;

    // Active table written directly; samples accepted on the same edge
    // still read the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_tbl <= '{default: '0};
        end else if (cfg_we && addr_ok) begin
            active_tbl[cfg_addr] <= cfg_wdata;
        end
    end
`endif

    // Handshake: stage 1 may advance whenever stage 2 is empty or draining
    logic s1_valid;
    logic adv1;
    logic adv2;
    logic accept;

    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;
    assign accept   = in_valid && adv1;

    // Segment decode; the upper node index is one wider so the top
    // segment reaches node NODES-1 without wrapping.
    logic [IDX_W-1:0] seg_lo;
    logic [IDX_W-1:0] seg_hi;

    assign seg_lo = {1'b0, in_data[DW_X-1:OFF_W]};
    assign seg_hi = seg_lo + IDX_W'(1);

    // Stage 1: capture bounding nodes and offset so a later commit cannot
    // change a sample already in flight.
    logic [DW_Y-1:0]  s1_ol;
    logic [DW_Y-1:0]  s1_oh;
    logic [OFF_W-1:0] s1_off;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_ol    <= '0;
            s1_oh    <= '0;
            s1_off   <= '0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_ol  <= active_tbl[seg_lo];
                s1_oh  <= active_tbl[seg_hi];
                s1_off <= in_data[OFF_W-1:0];
            end
        end
    end

    // Interpolation: signed slope times offset, arithmetic shift gives
    // floor division; the result stays between the two nodes so the
    // truncation back to DW_Y bits is exact.
    logic signed [DW_Y:0]   diff_c;
    logic signed [PW-1:0]   prod_c;
    logic signed [PW-1:0]   step_c;
    logic [DW_Y-1:0]        y_c;

    always_comb begin
        diff_c = $signed({1'b0, s1_oh}) - $signed({1'b0, s1_ol});
        prod_c = PW'(diff_c) * $signed({{(DW_Y+2){1'b0}}, s1_off});
        step_c = prod_c >>> OFF_W;
        y_c    = DW_Y'(PW'(s1_ol) + step_c);
    end

    // Stage 2: output register, held while back-pressured
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= y_c;
            end
        end
    end

endmodule

// File: tb/tb_pwl_curve_lut.sv
// Self-checking bench for pwl_curve_lut: directed curve checks plus random
// streams scored against an integer reference model of the node tables.
module tb_pwl_curve_lut;

    localparam int DW_X  = 10;
    localparam int DW_Y  = 9;
    localparam int SEG_W = 6;
    localparam int NODES = (1 << SEG_W) + 1;
    localparam int OFF_W = DW_X - SEG_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DW_X-1:0]   in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DW_Y-1:0]   out_data;
    logic              cfg_we;
    logic [SEG_W:0]    cfg_addr;
    logic [DW_Y-1:0]   cfg_wdata;
    logic              cfg_commit;

    always #5 clk = ~clk;

    pwl_curve_lut #(.DW_X(DW_X), .DW_Y(DW_Y), .SEG_W(SEG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_commit(cfg_commit)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          act_m [NODES];
    int          shd_m [NODES];
    int          exp_q [$];
    logic [31:0] last_data;
    bit          held;
    logic [31:0] held_data;
    bit          acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: y = OL + floor(off*(OH-OL) / 2^OFF_W), integer arithmetic
    function automatic int model_y(input int x);
        int seg, off, ol, oh, num, q, den;
        den = 1 << OFF_W;
        seg = x / den;
        off = x % den;
        ol  = act_m[seg];
        oh  = act_m[seg + 1];
        num = off * (oh - ol);
        if (num >= 0) q = num / den;
        else          q = -((-num + den - 1) / den);
        return ol + q;
    endfunction

    // Reference view of the configuration effect of one clock edge
    task automatic model_cfg(input bit we, input int addr, input int val, input bit commit);
`ifdef PWL_DOUBLE_BUFFER_EN
        if (commit) act_m = shd_m;
        if (we && addr < NODES) shd_m[addr] = val;
`else
        if (we && addr < NODES) act_m[addr] = val;
`endif
    endtask

    // One clock: check outputs at the falling edge, score handshakes,
    // advance the model, then return just after the rising edge.
    task automatic step();
        int e;
        @(negedge clk);
        if (held) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), held_data);
        end
        held      = out_valid && !out_ready;
        held_data = 32'(out_data);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("stream_data", 32'(out_data), 32'(e));
                last_data = 32'(out_data);
            end
        end
        acc = in_valid && in_ready;
        if (acc) exp_q.push_back(model_y(int'(in_data)));
        model_cfg(cfg_we, int'(cfg_addr), int'(cfg_wdata), cfg_commit);
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int addr, input int val);
        cfg_we = 1'b1; cfg_addr = (SEG_W+1)'(addr); cfg_wdata = DW_Y'(val);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
    endtask

    // Single sample through an empty pipe, with latency and value checks
    task automatic single(input int x, input int exp, input string tag);
        out_ready = 1'b1; in_valid = 1'b1; in_data = DW_X'(x);
        last_data = 'x;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk({tag, "_lat_n"}, 32'(out_valid), 32'd0);
        step();
        chk({tag, "_lat_n1"}, 32'(out_valid), 32'd1);
        step();
        chk(tag, last_data, 32'(exp));
    endtask

    task automatic drain(input string tag);
        in_valid = 1'b0; out_ready = 1'b1; cfg_we = 1'b0; cfg_commit = 1'b0;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
        chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        step();
        chk({tag, "_idle"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_commit = 1'b0;
        held = 1'b0; acc = 1'b0;
        act_m = '{default: 0};
        shd_m = '{default: 0};

        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        single(56, 0, "rst_nodes_zero");

        // Increasing segment
        cfg_write(3, 100);
        cfg_write(4, 164);
        commit();
        single(56, 132, "req019");

        // Node 3 rewritten: staged or immediate depending on build
        cfg_write(3, 0);
`ifdef PWL_DOUBLE_BUFFER_EN
        single(56, 132, "req023_before_commit");
        commit();
        single(56, 82, "req023_after_commit");
`else
        single(56, 82, "req023_direct");
        commit();
        single(56, 82, "req023_commit_ignored");
`endif

        // Decreasing segment, floor toward minus infinity
        cfg_write(10, 300);
        cfg_write(11, 200);
        commit();
        single(168, 250, "req020_mid");
        single(175, 206, "req020_floor");

        // Top segment, no index wrap
        cfg_write(63, 400);
        cfg_write(64, 511);
        commit();
        single(1023, 504, "req021_top");
        single(1008, 400, "req021_node63");

        // Out-of-range address must not disturb anything
        cfg_write(65, 5);
        cfg_write(127, 7);
        commit();
        single(1023, 504, "cfg_addr_oob");

        // Continuous stream with a 5-cycle stall
        in_valid = 1'b1;
        in_data  = DW_X'($urandom);
        for (int i = 0; i < 30; i++) begin
            out_ready = !(i >= 8 && i < 13);
            if (i == 10) chk("req022_in_ready_full", 32'(in_ready), 32'd0);
            if (i == 14) chk("req022_in_ready_resume", 32'(in_ready), 32'd1);
            step();
            if (acc) in_data = DW_X'($urandom);
        end
        drain("req022");

        // Random nodes, handshakes and commits mixed with traffic
        for (int i = 0; i < 400; i++) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(3) != 0);
                in_data  = DW_X'($urandom);
            end
            out_ready  = ($urandom_range(3) != 0);
            cfg_we     = ($urandom_range(3) == 0);
            cfg_addr   = (SEG_W+1)'($urandom_range(80));
            cfg_wdata  = DW_Y'($urandom);
            cfg_commit = ($urandom_range(15) == 0);
            step();
        end
        drain("random");

        // Reset with both stages occupied
        out_ready = 1'b0; in_valid = 1'b1; in_data = DW_X'(56);
        step(); step(); step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("req024_out_valid", 32'(out_valid), 32'd0);
        chk("req024_out_data", 32'(out_data), 32'd0);
        act_m = '{default: 0};
        shd_m = '{default: 0};
        exp_q.delete();
        held = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("req024_in_ready", 32'(in_ready), 32'd1);
        single(56, 0, "req024_after");
        drain("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
